// File: rtl/gen_wb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package gen_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TMO  = 2'd2
    } arb_state_e;

    // Bits needed to hold the value 'limit' (clog2(limit+1)), never less than 1.
    function automatic int cnt_width(input int limit);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (limit >= (1 << i)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gen_wb_watchdog.sv
// Slave-response watchdog: counts stalled strobe cycles of the current owner
// and flags when the count reaches TIMEOUT with no response in that cycle.
module gen_wb_watchdog
    import gen_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic stall_i,
    input  logic resp_i,
    output logic fire_o
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam bit ENABLE = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: a response or leaving ownership clears; stalls count up and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || resp_i) begin
            cnt_d = '0;
        end else if (stall_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A response landing in the limit cycle wins over the timeout.
    assign fire_o = ENABLE && (cnt_q == LIMIT) && !resp_i && !clr_i;

endmodule

// File: rtl/gen_arb_wb.sv
// Two-master round-robin Wishbone arbiter with bus lock and response watchdog.
module gen_arb_wb
    import gen_wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic [1:0]              gnt_o,
    output logic                    tmo_o
);

    arb_state_e state_q, state_d;
    logic       own_q, own_d;    // index of the granted master
    logic       last_q, last_d;  // master that owned the bus most recently

    logic own_cyc;
    logic own_stb;
    logic resp;
    logic fire;

    assign own_cyc = own_q ? wbm1_cyc_i : wbm0_cyc_i;
    assign own_stb = own_q ? wbm1_stb_i : wbm0_stb_i;
    assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;

    gen_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q != ST_OWN),
        .stall_i ((state_q == ST_OWN) && own_stb && !resp),
        .resp_i  (resp),
        .fire_o  (fire)
    );

    // Arbitration: round-robin on contention, hold while owner keeps cyc, one-cycle timeout state.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    own_d   = ~last_q;
                    state_d = ST_OWN;
                end else if (wbm0_cyc_i) begin
                    own_d   = 1'b0;
                    state_d = ST_OWN;
                end else if (wbm1_cyc_i) begin
                    own_d   = 1'b1;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = own_q;
                end else if (fire) begin
                    state_d = ST_TMO;
                end
            end
            ST_TMO: begin
                state_d = ST_IDLE;
                last_d  = own_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM registers; reset leaves master 1 as last owner so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end

    // Bus muxing: owner connects straight through; everyone else sees zeros.
    always_comb begin
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_sel_o  = '0;
        wbs_stb_o  = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbm0_dat_o = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm0_rty_o = 1'b0;
        wbm1_dat_o = '0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        wbm1_rty_o = 1'b0;
        if (state_q == ST_OWN) begin
            if (own_q) begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_we_o   = wbm1_we_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_stb_o  = wbm1_stb_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbm1_dat_o = wbs_dat_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i;
                wbm1_rty_o = wbs_rty_i;
            end else begin
                wbs_adr_o  = wbm0_adr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_we_o   = wbm0_we_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_stb_o  = wbm0_stb_i;
                wbs_cyc_o  = wbm0_cyc_i;
                wbm0_dat_o = wbs_dat_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i;
                wbm0_rty_o = wbs_rty_i;
            end
        end else if (state_q == ST_TMO) begin
            if (own_q) begin
                wbm1_err_o = 1'b1;
            end else begin
                wbm0_err_o = 1'b1;
            end
        end
    end

    assign gnt_o = (state_q == ST_IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
    assign tmo_o = (state_q == ST_TMO);

endmodule

// File: tb/tb_gen_arb_wb.sv
// Directed scoreboard bench for the two-master Wishbone arbiter.
module tb_gen_arb_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm0_adr_i, wbm0_dat_i, wbm1_adr_i, wbm1_dat_i;
    logic        wbm0_we_i, wbm0_stb_i, wbm0_cyc_i, wbm1_we_i, wbm1_stb_i, wbm1_cyc_i;
    logic [3:0]  wbm0_sel_i, wbm1_sel_i;
    logic [31:0] wbm0_dat_o, wbm1_dat_o;
    logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
    logic        wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [1:0]  gnt_o;
    logic        tmo_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          mst;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdat;
    } exp_t;
    exp_t sb_q[$];

    gen_arb_wb #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .SELECT_WIDTH (4),
        .TIMEOUT      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbm0_adr_i (wbm0_adr_i),
        .wbm0_dat_i (wbm0_dat_i),
        .wbm0_we_i  (wbm0_we_i),
        .wbm0_sel_i (wbm0_sel_i),
        .wbm0_stb_i (wbm0_stb_i),
        .wbm0_cyc_i (wbm0_cyc_i),
        .wbm0_dat_o (wbm0_dat_o),
        .wbm0_ack_o (wbm0_ack_o),
        .wbm0_err_o (wbm0_err_o),
        .wbm0_rty_o (wbm0_rty_o),
        .wbm1_adr_i (wbm1_adr_i),
        .wbm1_dat_i (wbm1_dat_i),
        .wbm1_we_i  (wbm1_we_i),
        .wbm1_sel_i (wbm1_sel_i),
        .wbm1_stb_i (wbm1_stb_i),
        .wbm1_cyc_i (wbm1_cyc_i),
        .wbm1_dat_o (wbm1_dat_o),
        .wbm1_ack_o (wbm1_ack_o),
        .wbm1_err_o (wbm1_err_o),
        .wbm1_rty_o (wbm1_rty_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .wbs_rty_i  (wbs_rty_i),
        .gnt_o      (gnt_o),
        .tmo_o      (tmo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
        if (n == 0) begin
            wbm0_cyc_i = cyc; wbm0_stb_i = stb; wbm0_we_i = we;
            wbm0_adr_i = adr; wbm0_dat_i = dat; wbm0_sel_i = 4'hF;
        end else begin
            wbm1_cyc_i = cyc; wbm1_stb_i = stb; wbm1_we_i = we;
            wbm1_adr_i = adr; wbm1_dat_i = dat; wbm1_sel_i = 4'hF;
        end
    endtask

    // Slave acks the current beat; the oldest expected beat is popped and compared.
    task automatic sb_ack();
        exp_t e;
        chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            wbs_dat_i = e.rdat;
            wbs_ack_i = 1'b1;
            #1;
            chk("sb_gnt", 64'(gnt_o), e.mst ? 64'd2 : 64'd1);
            chk("sb_adr", 64'(wbs_adr_o), 64'(e.adr));
            chk("sb_wdat", 64'(wbs_dat_o), 64'(e.dat));
            chk("sb_ack_owner", 64'(e.mst ? wbm1_ack_o : wbm0_ack_o), 64'd1);
            chk("sb_ack_other", 64'(e.mst ? wbm0_ack_o : wbm1_ack_o), 64'd0);
            chk("sb_rdat", 64'(e.mst ? wbm1_dat_o : wbm0_dat_o), 64'(e.rdat));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 0, 32'h0, 32'h0);
        wbs_dat_i = 32'h0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("rst_tmo", 64'(tmo_o), 64'd0);
        rst_n = 1'b1;

        // Simultaneous requests: m0, then m1, then m0 again.
        tick();
        drv(0, 1, 0, 0, 32'h0, 32'h0);
        drv(1, 1, 0, 0, 32'h0, 32'h0);
        #1; chk("rr_req_idle", 64'(gnt_o), 64'd0);
        tick(); #1; chk("rr_first_m0", 64'(gnt_o), 64'd1);
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        #1; chk("rr_hold_until_edge", 64'(gnt_o), 64'd1);
        tick(); #1; chk("rr_idle_gap", 64'(gnt_o), 64'd0);
        tick(); #1; chk("rr_second_m1", 64'(gnt_o), 64'd2);
        drv(1, 0, 0, 0, 32'h0, 32'h0);
        tick(); #1; chk("rr_idle2", 64'(gnt_o), 64'd0);
        drv(0, 1, 0, 0, 32'h0, 32'h0);
        drv(1, 1, 0, 0, 32'h0, 32'h0);
        tick(); #1; chk("rr_third_m0", 64'(gnt_o), 64'd1);
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 0, 32'h0, 32'h0);
        tick(); #1; chk("rr_idle3", 64'(gnt_o), 64'd0);

        // Single m0 write, slave acks two cycles after the grant.
        tick();
        drv(0, 1, 1, 1, 32'h10, 32'hA5);
        sb_q.push_back('{mst: 1'b0, adr: 32'h10, dat: 32'hA5, rdat: 32'h1234_5678});
        #1; chk("wr_idle_no_pass", 64'(wbs_cyc_o), 64'd0);
        tick(); #1;
        chk("wr_gnt", 64'(gnt_o), 64'd1);
        chk("wr_wbs_dat", 64'(wbs_dat_o), 64'hA5);
        chk("wr_wbs_cyc", 64'(wbs_cyc_o), 64'd1);
        chk("wr_no_ack_yet", 64'(wbm0_ack_o), 64'd0);
        tick(); #1; chk("wr_wait_no_ack", 64'(wbm0_ack_o), 64'd0);
        tick(); sb_ack();
        chk("wr_m1_quiet", 64'({wbm1_dat_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o}), 64'd0);
        tick();
        wbs_ack_i = 1'b0;
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        #1; chk("wr_ack_once", 64'(wbm0_ack_o), 64'd0);
        tick(); #1; chk("wr_release", 64'(gnt_o), 64'd0);

        // m1 locks the bus for four acked beats while m0 waits.
        drv(1, 1, 1, 1, 32'h20, 32'h100);
        tick(); #1; chk("lock_gnt_m1", 64'(gnt_o), 64'd2);
        drv(0, 1, 1, 1, 32'h30, 32'hBEEF);
        for (int b = 0; b < 4; b++) begin
            drv(1, 1, 1, 1, 32'h20 + 32'(b), 32'h100 + 32'(b));
            sb_q.push_back('{mst: 1'b1, adr: 32'h20 + 32'(b), dat: 32'h100 + 32'(b),
                             rdat: 32'hC0DE_0000 + 32'(b)});
            sb_ack();
            chk("lock_m0_no_ack", 64'(wbm0_ack_o), 64'd0);
            tick();
        end
        wbs_ack_i = 1'b0;
        drv(1, 0, 0, 0, 32'h0, 32'h0);
        #1; chk("lock_still_m1", 64'(gnt_o), 64'd2);
        tick(); #1; chk("lock_idle_gap", 64'(gnt_o), 64'd0);
        tick(); #1; chk("lock_then_m0", 64'(gnt_o), 64'd1);
        sb_q.push_back('{mst: 1'b0, adr: 32'h30, dat: 32'hBEEF, rdat: 32'h0BAD_F00D});
        sb_ack();
        tick();
        wbs_ack_i = 1'b0;
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // Slave never answers: eight stalled cycles, then one timeout cycle.
        drv(0, 1, 1, 0, 32'h40, 32'h0);
        tick();
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("wd_no_tmo_yet", 64'(tmo_o), 64'd0);
            chk("wd_no_err_yet", 64'(wbm0_err_o), 64'd0);
            tick();
        end
        #1;
        chk("wd_tmo", 64'(tmo_o), 64'd1);
        chk("wd_err", 64'(wbm0_err_o), 64'd1);
        chk("wd_cyc_drop", 64'(wbs_cyc_o), 64'd0);
        chk("wd_stb_drop", 64'(wbs_stb_o), 64'd0);
        chk("wd_m1_err", 64'(wbm1_err_o), 64'd0);
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        tick(); #1;
        chk("wd_tmo_one_cycle", 64'(tmo_o), 64'd0);
        chk("wd_err_one_cycle", 64'(wbm0_err_o), 64'd0);
        chk("wd_back_idle", 64'(gnt_o), 64'd0);

        // Ack arrives exactly in the cycle the counter hits the limit.
        drv(0, 1, 1, 0, 32'h50, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1; chk("late_no_tmo", 64'(tmo_o), 64'd0);
            tick();
        end
        sb_q.push_back('{mst: 1'b0, adr: 32'h50, dat: 32'h0, rdat: 32'h5A5A_5A5A});
        sb_ack();
        chk("late_no_err", 64'(wbm0_err_o), 64'd0);
        chk("late_no_tmo_ack", 64'(tmo_o), 64'd0);
        tick();
        wbs_ack_i = 1'b0;
        #1;
        chk("late_no_tmo_after", 64'(tmo_o), 64'd0);
        chk("late_no_err_after", 64'(wbm0_err_o), 64'd0);
        chk("late_still_owned", 64'(gnt_o), 64'd1);

        // Reset mid-beat with the slave acking: everything drops at once.
        wbs_ack_i = 1'b1;
        drv(1, 1, 1, 0, 32'h60, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt_o), 64'd0);
        chk("arst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("arst_wbs_stb", 64'(wbs_stb_o), 64'd0);
        chk("arst_wbs_adr", 64'(wbs_adr_o), 64'd0);
        chk("arst_m0_ack", 64'(wbm0_ack_o), 64'd0);
        chk("arst_m0_dat", 64'(wbm0_dat_o), 64'd0);
        chk("arst_tmo", 64'(tmo_o), 64'd0);
        tick(); #1;
        chk("arst_hold_gnt", 64'(gnt_o), 64'd0);
        chk("arst_hold_ack", 64'(wbm0_ack_o | wbm1_ack_o), 64'd0);
        wbs_ack_i = 1'b0;
        rst_n = 1'b1;
        tick(); #1;
        chk("arst_m0_wins", 64'(gnt_o), 64'd1);
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen_arb_wb.md
GEN_ARB_WB -- requirements
Module: gen_arb_wb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits (8/16/32/64).
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, slave-response watchdog limit in cycles; 0 disables the watchdog.
REQ-005 clk  input  1  the only clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 wbm<n>_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i  input  ADDR_WIDTH/DATA_WIDTH/1/SELECT_WIDTH/1/1  master n (n=0,1) request bundle.
REQ-008 wbm<n>_dat_o/ack_o/err_o/rty_o  output  DATA_WIDTH/1/1/1  master n response bundle.
REQ-009 wbs_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o  output  ADDR_WIDTH/DATA_WIDTH/1/SELECT_WIDTH/1/1  shared slave-side request (feeds the address-decode mux).
REQ-010 wbs_dat_i/ack_i/err_i/rty_i  input  DATA_WIDTH/1/1/1  shared slave-side response.
REQ-011 gnt_o  output  2  one-hot current grant; 2'b00 when idle.
REQ-012 tmo_o  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-013 FSM states: IDLE, OWN, TMO; grant index and last-owner bit are registered.
REQ-014 IDLE: if exactly one wbm<n>_cyc_i is high, grant n at the next edge and enter OWN.
REQ-015 IDLE, both cyc high: grant the master that is not last-owner (round-robin).
REQ-016 IDLE: all wbs_* request outputs are 0; all wbm ack/err/rty outputs are 0; no ack is passed through during arbitration.
REQ-017 OWN: wbs_* request outputs equal the granted master's inputs combinationally; the granted master's dat_o/ack_o/err_o/rty_o equal wbs_* inputs; the non-granted master sees dat_o=0 and ack/err/rty=0.
REQ-018 OWN: grant is held while the owner's cyc_i is high, across any number of stb/ack beats (bus lock).
REQ-019 OWN: when the owner's cyc_i is sampled low, return to IDLE at that edge and set last-owner to the owner; new arbitration costs one idle cycle.
REQ-020 Watchdog counter: cleared on entry to OWN and on every cycle with wbs ack_i, err_i or rty_i high; increments while owner stb_i is high with no response.
REQ-021 Watchdog fire: when TIMEOUT is nonzero and the counter equals TIMEOUT, move to TMO at the next edge.
REQ-022 TMO lasts one cycle: wbs_stb_o=0 and wbs_cyc_o=0; owner err_o=1; tmo_o=1; then return to IDLE with last-owner set to the owner.
REQ-023 Counter width is clog2(TIMEOUT+1) with a minimum of 1 bit; the counter saturates and never wraps.
REQ-024 A response arriving in the same cycle the counter reaches TIMEOUT takes precedence: it clears the counter and no TMO occurs.
REQ-025 A non-owner raising cyc_i during OWN or TMO only waits; it causes no glitch on any output.

Reset
REQ-026 rst_n low asynchronously forces IDLE, grant none, last-owner=1 (master 0 wins first), and counter=0.
REQ-027 During reset, all outputs are 0.
REQ-028 Reset asserted mid-transfer drops wbs_cyc_o immediately; no ack is delivered afterwards.

Structure
REQ-029 A shared package gen_wb_pkg holds the state enum (IDLE/OWN/TMO) and the clog2-based counter-width function.
REQ-030 One natural sub-module is gen_wb_watchdog, which contains the counter and the fire compare; the arbiter FSM and the muxing stay in gen_arb_wb.

Verification
REQ-031 m0 cyc/stb write with adr=0x10 and dat=0xA5; slave acks 2 cycles later -> gnt_o=01 one cycle after the request; wbs_dat_o=0xA5; wbm0_ack_o pulses once; wbm1 outputs stay 0.
REQ-032 Both masters request in the same cycle after reset -> m0 is granted first; after m0 drops cyc and one IDLE cycle, m1 is granted; a further simultaneous request grants m0.
REQ-033 m1 holds cyc for 4 back-to-back acked beats while m0 requests -> gnt_o stays 10 through all 4 beats; m0 is granted only after m1 drops cyc.
REQ-034 TIMEOUT=8, slave never responds -> after 8 stalled cycles: wbm owner err_o=1 and tmo_o=1 for exactly one cycle, wbs_cyc_o=0, then IDLE.
REQ-035 TIMEOUT=8, ack arrives on the 8th stalled cycle -> a normal ack occurs with no err and no tmo_o.
REQ-036 rst_n pulsed low mid-beat -> all outputs are 0 in the same cycle; after release, m0 wins a simultaneous request.
